// File: rtl/counter_bn.sv
// counter_bn: parametrised up/down/down-by-3/load counter with exact carry/borrow, optional saturation and a wrap-event counter
module counter_bn #(
    parameter int WIDTH    = 32,
    parameter int SATURATE = 0,
    parameter int WRAPW    = 8
) (
    input  logic             bn_clk,
    input  logic             bn_reset,
    input  logic             bn_enable,
    input  logic [1:0]       bn_mode,
    input  logic [WIDTH-1:0] bn_D,
    output logic             bn_load,
    output logic             bn_rco,
    output logic [WIDTH-1:0] bn_Q,
    output logic [WRAPW-1:0] bn_wrap_cnt
);
    logic [WIDTH:0]   ext, up, dn1, dn3;
    logic             hit;
    logic [WIDTH-1:0] wrapped, held, q_nxt;
    // One extra bit so the MSB is the exact carry/borrow out of the full width
    assign ext = {1'b0, bn_Q};
    assign up  = ext + (WIDTH+1)'(1);
    assign dn1 = ext - (WIDTH+1)'(1);
    assign dn3 = ext - (WIDTH+1)'(3);
    always_comb begin
        hit     = bn_mode == 2'b00 ? up[WIDTH] : bn_mode == 2'b01 ? dn1[WIDTH] : bn_mode == 2'b10 ? dn3[WIDTH] : 1'b0;
        wrapped = bn_mode == 2'b00 ? up[WIDTH-1:0] : bn_mode == 2'b01 ? dn1[WIDTH-1:0] : dn3[WIDTH-1:0];
        held    = bn_mode == 2'b00 ? {WIDTH{1'b1}} : '0;
        q_nxt   = bn_mode == 2'b11 ? bn_D : (hit && SATURATE != 0) ? held : wrapped;
    end
    always_ff @(posedge bn_clk) begin
        if (bn_reset) begin
            bn_Q        <= '0;
            bn_load     <= 1'b0;
            bn_rco      <= 1'b0;
            bn_wrap_cnt <= '0;
        end else begin
            bn_load <= bn_enable && bn_mode == 2'b11;
            bn_rco  <= bn_enable && hit;
            if (bn_enable)
                bn_Q <= q_nxt;
            if (bn_enable && hit && !(&bn_wrap_cnt))
                bn_wrap_cnt <= bn_wrap_cnt + WRAPW'(1);
        end
    end
endmodule
